// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback wins, and MDU results wait in a small FIFO.
// It keeps a pending-destination scoreboard for decode hazards and raises a stall when the FIFO head starves.
module rf_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_wr_en,
    input  logic [4:0]  pipe_wr_addr,
    input  logic [31:0] pipe_wr_data,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    output logic        hazard,
    output logic        pipe_stall,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [7:0]    STARVE_MAX = 8'(STARVE_LIMIT);

    function automatic logic [31:0] reg_mask(input logic [4:0] idx);
        reg_mask = 32'd1 << idx;
    endfunction

    logic [4:0]    fifo_rd_r   [DEPTH];
    logic [31:0]   fifo_data_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [7:0]    starve_r;
    logic [31:0]   pending_r;
    logic          rf_from_mdu_r;

    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic [4:0]    head_rd_s;
    logic [31:0]   head_data_s;
    logic [31:0]   clr_mask_s;
    logic [31:0]   set_mask_s;
    logic [31:0]   pending_next_s;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign empty_s     = (count_r == {CW{1'b0}});
    assign full_s      = (count_r == FULL_CNT);
    assign mdu_ready   = ~rst & ~full_s;
    assign push_s      = mdu_valid & mdu_ready;
    assign pop_s       = ~pipe_wr_en & ~empty_s;
    assign head_rd_s   = fifo_rd_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    assign clr_mask_s     = (rf_wr_en & rf_from_mdu_r) ? reg_mask(rf_wr_addr) : 32'd0;
    assign set_mask_s     = mdu_issue ? reg_mask(mdu_issue_rd) : 32'd0;
    assign pending_next_s = ((pending_r & ~clr_mask_s) | set_mask_s) & ~32'd1;

    assign hazard     = ~rst & (pending_r[dec_rs1] | pending_r[dec_rs2] | pending_r[dec_rd]);
    assign pipe_stall = ~rst & (starve_r == STARVE_MAX);

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_rd_r[wr_ptr_r]   <= mdu_rd;
            fifo_data_r[wr_ptr_r] <= mdu_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter for the FIFO head, saturating at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_r <= 8'd0;
        end else if (pop_s || empty_s) begin
            starve_r <= 8'd0;
        end else if (starve_r != STARVE_MAX) begin
            starve_r <= starve_r + 8'd1;
        end else begin
            starve_r <= starve_r;
        end
    end

    // Registered register-file write port; x0 targets load addr/data but never enable
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= 5'd0;
            rf_wr_data    <= 32'd0;
            rf_from_mdu_r <= 1'b0;
        end else if (pipe_wr_en) begin
            rf_wr_en      <= (pipe_wr_addr != 5'd0);
            rf_wr_addr    <= pipe_wr_addr;
            rf_wr_data    <= pipe_wr_data;
            rf_from_mdu_r <= 1'b0;
        end else if (pop_s) begin
            rf_wr_en      <= (head_rd_s != 5'd0);
            rf_wr_addr    <= head_rd_s;
            rf_wr_data    <= head_data_s;
            rf_from_mdu_r <= 1'b1;
        end else begin
            rf_wr_en      <= 1'b0;
            rf_from_mdu_r <= 1'b0;
        end
    end

    // Pending-write scoreboard; a new issue overrides a same-cycle commit clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 32'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for pipeline writes plus
// hand-written sequences for the MDU path, contention, starvation, collisions and reset.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wr_en;
    logic [4:0]  pipe_wr_addr;
    logic [31:0] pipe_wr_data;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_rd;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        pipe_stall;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        pipe_en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    rf_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .hazard(hazard), .pipe_stall(pipe_stall),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_rf(input string name, input logic en, input logic [4:0] addr, input logic [31:0] data);
        chk({name, ".en"}, 32'(rf_wr_en), 32'(en));
        chk({name, ".addr"}, 32'(rf_wr_addr), 32'(addr));
        chk({name, ".data"}, rf_wr_data, data);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h12345678};
        vecs[2] = '{1'b0, 5'd9,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h12345678};
        vecs[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 5'd3,  32'h00000000, 1'b0, 5'd31, 32'hA5A5A5A5};
        vecs[5] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};

        rst = 1'b1;
        pipe_wr_en = 1'b0; pipe_wr_addr = 5'd0; pipe_wr_data = 32'd0;
        mdu_issue = 1'b0; mdu_issue_rd = 5'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;

        // Reset state
        tick(); tick();
        chk("rst.mdu_ready", 32'(mdu_ready), 32'd0);
        chk("rst.hazard", 32'(hazard), 32'd0);
        chk("rst.pipe_stall", 32'(pipe_stall), 32'd0);
        chk_rf("rst.rf", 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        tick();
        chk("release.mdu_ready", 32'(mdu_ready), 32'd1);

        // Pipeline-only vectors
        for (int i = 0; i < 6; i++) begin
            pipe_wr_en   = vecs[i].pipe_en;
            pipe_wr_addr = vecs[i].addr;
            pipe_wr_data = vecs[i].data;
            tick();
            chk_rf($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_data);
        end
        pipe_wr_en = 1'b0;
        tick();

        // MDU path with scoreboard
        mdu_issue = 1'b1; mdu_issue_rd = 5'd7;
        tick();
        mdu_issue = 1'b0;
        dec_rs1 = 5'd7;
        #1;
        chk("mdu.hazard_set", 32'(hazard), 32'd1);
        mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
        chk("mdu.ready", 32'(mdu_ready), 32'd1);
        tick();
        mdu_valid = 1'b0;
        chk("mdu.t1p1_en", 32'(rf_wr_en), 32'd0);
        tick();
        chk_rf("mdu.t1p2", 1'b1, 5'd7, 32'h1234);
        chk("mdu.t1p2_hazard", 32'(hazard), 32'd1);
        tick();
        chk("mdu.t1p3_hazard", 32'(hazard), 32'd0);
        chk("mdu.t1p3_en", 32'(rf_wr_en), 32'd0);
        dec_rs1 = 5'd0;

        // Contention: pipeline first, MDU next cycle
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd3; pipe_wr_data = 32'hA;
        mdu_valid = 1'b1; mdu_rd = 5'd4; mdu_data = 32'hB;
        tick();
        pipe_wr_en = 1'b0; mdu_valid = 1'b0;
        chk_rf("cont.pipe", 1'b1, 5'd3, 32'hA);
        tick();
        chk_rf("cont.mdu", 1'b1, 5'd4, 32'hB);
        tick();
        chk("cont.idle_en", 32'(rf_wr_en), 32'd0);

        // Full FIFO and starvation with continuous pipeline writes
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd11; pipe_wr_data = 32'h11;
        mdu_valid = 1'b1; mdu_rd = 5'd20; mdu_data = 32'd100;
        tick();                                   // c0: push 20
        mdu_rd = 5'd21; mdu_data = 32'd101;
        chk("full.c1_ready", 32'(mdu_ready), 32'd1);
        chk_rf("full.c1_pipe", 1'b1, 5'd11, 32'h11);
        tick();                                   // c1: push 21
        mdu_rd = 5'd22; mdu_data = 32'd102;
        chk("full.c2_ready", 32'(mdu_ready), 32'd0);
        tick(); tick();                           // c2, c3
        chk("full.c4_stall", 32'(pipe_stall), 32'd0);
        chk("full.c4_ready", 32'(mdu_ready), 32'd0);
        tick();
        chk("full.c5_stall", 32'(pipe_stall), 32'd1);
        pipe_wr_en = 1'b0;
        tick();                                   // c5: pop 20
        chk_rf("drain.e20", 1'b1, 5'd20, 32'd100);
        chk("drain.c6_stall", 32'(pipe_stall), 32'd0);
        chk("drain.c6_ready", 32'(mdu_ready), 32'd1);
        tick();                                   // c6: pop 21, push 22
        mdu_valid = 1'b0;
        chk_rf("drain.e21", 1'b1, 5'd21, 32'd101);
        tick();                                   // c7: pop 22
        chk_rf("drain.e22", 1'b1, 5'd22, 32'd102);
        tick();
        chk("drain.done_en", 32'(rf_wr_en), 32'd0);
        chk("drain.done_stall", 32'(pipe_stall), 32'd0);
        chk("drain.done_ready", 32'(mdu_ready), 32'd1);

        // Scoreboard set/clear collision on the same register
        mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
        tick();
        mdu_issue = 1'b0;
        mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h99;
        tick();
        mdu_valid = 1'b0;
        tick();
        chk_rf("coll.commit", 1'b1, 5'd9, 32'h99);
        mdu_issue = 1'b1; mdu_issue_rd = 5'd9;
        tick();
        mdu_issue = 1'b0;
        dec_rs2 = 5'd9;
        #1;
        chk("coll.hazard", 32'(hazard), 32'd1);
        tick();
        chk("coll.hazard_hold", 32'(hazard), 32'd1);

        // Reset mid-operation with a full FIFO and pending[9] set
        pipe_wr_en = 1'b1; pipe_wr_addr = 5'd0; pipe_wr_data = 32'd0;
        mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC;
        tick();
        mdu_rd = 5'd13; mdu_data = 32'hD;
        tick();
        mdu_valid = 1'b0;
        chk("rstmid.full", 32'(mdu_ready), 32'd0);
        rst = 1'b1; pipe_wr_en = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid.hazard", 32'(hazard), 32'd0);
        chk("rstmid.en0", 32'(rf_wr_en), 32'd0);
        chk("rstmid.ready", 32'(mdu_ready), 32'd1);
        tick();
        chk("rstmid.en1", 32'(rf_wr_en), 32'd0);
        tick();
        chk("rstmid.en2", 32'(rf_wr_en), 32'd0);
        chk("rstmid.stall", 32'(pipe_stall), 32'd0);
        dec_rs2 = 5'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback result and the multi-cycle mul/div unit (MDU). It buffers MDU results in a small FIFO, tracks destination registers of in-flight MDU operations on a scoreboard for decode hazard detection, and forces a pipeline stall when a buffered MDU result has waited too long. It sits between the writeback mux/MDU and the register file.

## Interface
- DEPTH, 2, MDU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before pipe_stall asserts (1..255)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pipe_wr_en  in  1  pipeline writeback valid this cycle
- pipe_wr_addr  in  5  pipeline destination register
- pipe_wr_data  in  32  pipeline writeback data
- mdu_issue  in  1  MDU operation issued by decode this cycle
- mdu_issue_rd  in  5  destination register of issued MDU op
- mdu_valid  in  1  MDU result available
- mdu_ready  out  1  FIFO can accept result (= not full, 0 while rst)
- mdu_rd  in  5  MDU result destination register
- mdu_data  in  32  MDU result data
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage register indices
- hazard  out  1  any decode index has a pending MDU write
- pipe_stall  out  1  pipeline must insert bubbles so FIFO can drain
- rf_wr_en  out  1  register-file write enable (registered)
- rf_wr_addr  out  5  register-file write address (registered)
- rf_wr_data  out  32  register-file write data (registered)

## Operation
- Push: mdu_valid & mdu_ready stores {mdu_rd, mdu_data} at FIFO tail.
- Grant each cycle: pipe_wr_en wins; else if FIFO non-empty, pop head. No pop when pipe_wr_en=1, even during pipe_stall (pipe_wr_en during stall is an upstream error; pipeline still wins).
- Registered output: granted source's addr/data loaded at clock edge; rf_wr_en=1 only if granted and addr≠0. x0 writes dropped (rf_wr_en=0, addr/data still loaded). No grant: rf_wr_en=0, addr/data hold.
- Scoreboard: 32 pending bits, bit 0 hard-wired 0. mdu_issue sets pending[mdu_issue_rd]. Clear pending[a] at the edge ending the cycle in which rf_wr_en=1 carries a popped MDU entry to address a. Simultaneous set and clear of same index: set wins.
- hazard = pending[dec_rs1] | pending[dec_rs2] | pending[dec_rd] (combinational; dec_rd check prevents WAW).
- Starvation counter (8-bit): reset to 0 on pop or when FIFO empty; else +1 per cycle FIFO non-empty, saturating at STARVE_LIMIT. pipe_stall = (counter == STARVE_LIMIT), combinational.
- FIFO full: mdu_ready=0; MDU holds mdu_valid/data. Push and pop in same cycle when full: pop occurs, push refused (mdu_ready derived from registered count, no pass-through).
- Empty FIFO: push not visible to grant until next cycle (no bypass).

## Timing
- Reset (rst high at edge): FIFO empty, pending all 0, counter 0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0; hazard=0, pipe_stall=0, mdu_ready=0 during rst, 1 cycle after release.
- Pipeline write in cycle t → rf_wr_en high in cycle t+1.
- MDU push in cycle t, no pipeline traffic → pop t+1 → rf_wr_en high t+2 → pending clear, hazard low in t+3.
- Starvation: FIFO non-empty from t with continuous pipe_wr_en → pipe_stall high in cycle t+STARVE_LIMIT; stays high until the cycle after a pop.
- Reset mid-operation discards FIFO contents and pending bits; no RF write in the cycle after reset.

## Test plan
- Pipeline only: pipe_wr_en=1, addr=5, data=0xDEADBEEF at t → rf_wr_en=1, addr 5, data 0xDEADBEEF at t+1; addr=0 at t → rf_wr_en=0 at t+1.
- MDU path + scoreboard: mdu_issue rd=7 at t0; dec_rs1=7 → hazard=1; mdu_valid rd=7 data=0x1234 at t1, idle pipe → rf write (7,0x1234) at t1+2, hazard=0 at t1+3.
- Contention: pipe write (3,0xA) and MDU push (4,0xB) same cycle t → (3,0xA) at t+1, (4,0xB) at t+2.
- Full/starvation (DEPTH=2, STARVE_LIMIT=4): continuous pipe_wr_en, three MDU results → mdu_ready=0 after 2 pushes, pipe_stall=1 four cycles after first push; drop pipe_wr_en → entries drain in order, pipe_stall and counter clear, mdu_ready returns 1.
- Set/clear collision: MDU result for rd=9 committing while mdu_issue rd=9 in same cycle → pending[9] remains 1, hazard stays high for dec_rs2=9.
- Reset mid-operation: two FIFO entries, pending[9]=1, assert rst one cycle → FIFO empty, hazard=0, no rf_wr_en afterwards.
